// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched
//   Round-robin owner scheduler for a shared 4:1 single-bit select datapath.
//   The block picks one requester at a time and drives the mux select and a
//   one-hot grant. Each grant lasts at most MAX_HOLD cycles. Every grant is
//   followed by one idle GAP cycle so the gate-level mux can settle before
//   the next owner takes over. The muxed bit is registered on out.
//
//   Optional feature macro: ARB_LOCK_EN
//     When defined, the block has an extra input, lock. While lock=1 and the
//     current owner keeps requesting, hold_cnt freezes and the hold limit
//     does not expire.
//
// Parameters
//   MAX_HOLD : maximum consecutive grant cycles per owner (1..255)
//   CNT_W    : hold counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req[3:0] in   level-sensitive requests, req[i] from requester i
//   d[3:0]   in   data bits, d[i] belongs to requester i
//   lock     in   (ARB_LOCK_EN only) extends the current grant past MAX_HOLD
//   grant    out  one-hot grant, zero when there is no owner
//   sel      out  mux select = index of the owner; keeps its value in GAP/IDLE
//   valid    out  high while in GRANT
//   out      out  registered d[sel], zero when the previous cycle was not a grant
//   hold_cnt out  cycles elapsed in the current grant (debug)
//
// Handshake: req is a level. A requester owns the datapath in the cycle
// where its grant bit is high. Dropping req ends the grant at the next edge.
module mux4_rr_sched #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [3:0]       d,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [3:0]       grant,
  output logic [1:0]       sel,
  output logic             valid,
  output logic             out,
  output logic [CNT_W-1:0] hold_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state, state_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic [CNT_W-1:0] hold_nxt;
  logic [1:0]       winner;
  logic             lock_hold;

`ifdef ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // First asserted request at or after p, wrapping 3 -> 0.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign winner = rr_pick(req, ptr);
  assign valid  = (state == GRANT);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    grant_nxt = grant;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE, GAP: begin
        grant_nxt = 4'b0000;
        hold_nxt  = '0;
        if (|req) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          grant_nxt = 4'b0001 << winner;
        end else begin
          state_nxt = IDLE;
        end
      end
      GRANT: begin
        if (req[sel] && lock_hold) begin
          // Locked owner: counter frozen, limit suppressed.
          hold_nxt = hold_cnt;
        end else if (req[sel] && (hold_cnt != HOLD_LAST)) begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end else begin
          // Released or expired: rotate priority past the current owner.
          state_nxt = GAP;
          ptr_nxt   = sel + 2'd1;
          grant_nxt = 4'b0000;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      sel      <= 2'd0;
      grant    <= 4'b0000;
      hold_cnt <= '0;
      out      <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      grant    <= grant_nxt;
      hold_cnt <= hold_nxt;
      out      <= valid ? d[sel] : 1'b0;
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// tb_mux4_rr_sched
//   Directed bench for mux4_rr_sched. Three instances share one set of
//   inputs: MAX_HOLD=4 (dut4), MAX_HOLD=2 (dut2) and MAX_HOLD=1 (dut1).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that same
//   point, after the edge has updated the registers.
module tb_mux4_rr_sched;

  localparam int CW = 8;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req;
  logic [3:0]    d;
  logic          lock;

  logic [3:0]    g4, g2, g1;
  logic [1:0]    s4, s2, s1;
  logic          v4, v2, v1;
  logic          o4, o2, o1;
  logic [CW-1:0] h4, h2, h1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Contention tables, one entry per cycle after req=1111 is applied.
  localparam logic [3:0] EG2 [13] = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
                                      4'b0100, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0001};
  localparam logic [1:0] ES2 [13] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
                                      2'd3, 2'd3, 2'd3, 2'd0};
  localparam logic [3:0] EG1 [13] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                                      4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
  localparam logic [1:0] ES1 [13] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                                      2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  mux4_rr_sched #(.MAX_HOLD(4), .CNT_W(CW)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(g4), .sel(s4), .valid(v4), .out(o4), .hold_cnt(h4));

  mux4_rr_sched #(.MAX_HOLD(2), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(g2), .sel(s2), .valid(v2), .out(o2), .hold_cnt(h2));

  mux4_rr_sched #(.MAX_HOLD(1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .d(d),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .grant(g1), .sel(s1), .valid(v1), .out(o1), .hold_cnt(h1));

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'h0;
    lock  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req = 4'b0000; d = 4'h0; lock = 1'b0;
    #3;
    n_cmp++; if (g4 !== 4'b0000) begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", g4); end
    n_cmp++; if (s4 !== 2'd0)    begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", s4); end
    n_cmp++; if (v4 !== 1'b0)    begin n_fail++; $display("FAIL reset_valid got=%b exp=0", v4); end
    n_cmp++; if (o4 !== 1'b0)    begin n_fail++; $display("FAIL reset_out got=%b exp=0", o4); end
    n_cmp++; if (h4 !== '0)      begin n_fail++; $display("FAIL reset_hold got=%0d exp=0", h4); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (g2 !== 4'b0000) begin n_fail++; $display("FAIL reset_idle_grant got=%b exp=0000", g2); end
  endtask

  task automatic test_single_hold();
    logic [CW-1:0] exp_h;
    apply_reset();
    req = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_h = CW'(k);
      n_cmp++; if (g4 !== 4'b0001) begin n_fail++; $display("FAIL single_grant[%0d] got=%b exp=0001", k, g4); end
      n_cmp++; if (h4 !== exp_h)   begin n_fail++; $display("FAIL single_hold[%0d] got=%0d exp=%0d", k, h4, exp_h); end
      n_cmp++; if (v4 !== 1'b1)    begin n_fail++; $display("FAIL single_valid[%0d] got=%b exp=1", k, v4); end
    end
    tick();
    n_cmp++; if (g4 !== 4'b0000) begin n_fail++; $display("FAIL single_gap_grant got=%b exp=0000", g4); end
    n_cmp++; if (v4 !== 1'b0)    begin n_fail++; $display("FAIL single_gap_valid got=%b exp=0", v4); end
    n_cmp++; if (s4 !== 2'd0)    begin n_fail++; $display("FAIL single_gap_sel got=%0d exp=0", s4); end
    tick();
    n_cmp++; if (g4 !== 4'b0001) begin n_fail++; $display("FAIL single_regrant got=%b exp=0001", g4); end
    n_cmp++; if (h4 !== '0)      begin n_fail++; $display("FAIL single_regrant_hold got=%0d exp=0", h4); end
  endtask

  task automatic test_contention();
    apply_reset();
    req = 4'b1111;
    for (int k = 0; k < 13; k++) begin
      tick();
      n_cmp++; if (g2 !== EG2[k]) begin n_fail++; $display("FAIL cont2_grant[%0d] got=%b exp=%b", k, g2, EG2[k]); end
      n_cmp++; if (s2 !== ES2[k]) begin n_fail++; $display("FAIL cont2_sel[%0d] got=%0d exp=%0d", k, s2, ES2[k]); end
      n_cmp++; if (v2 !== (EG2[k] != 4'b0000)) begin n_fail++; $display("FAIL cont2_valid[%0d] got=%b exp=%b", k, v2, (EG2[k] != 4'b0000)); end
      n_cmp++; if (g1 !== EG1[k]) begin n_fail++; $display("FAIL cont1_grant[%0d] got=%b exp=%b", k, g1, EG1[k]); end
      n_cmp++; if (s1 !== ES1[k]) begin n_fail++; $display("FAIL cont1_sel[%0d] got=%0d exp=%0d", k, s1, ES1[k]); end
    end
  endtask

  task automatic test_early_release();
    apply_reset();
    req = 4'b0101;
    tick();
    n_cmp++; if (g4 !== 4'b0001) begin n_fail++; $display("FAIL early_first got=%b exp=0001", g4); end
    req = 4'b0100;
    tick();
    n_cmp++; if (g4 !== 4'b0000) begin n_fail++; $display("FAIL early_gap got=%b exp=0000", g4); end
    tick();
    n_cmp++; if (g4 !== 4'b0100) begin n_fail++; $display("FAIL early_next_grant got=%b exp=0100", g4); end
    n_cmp++; if (s4 !== 2'd2)    begin n_fail++; $display("FAIL early_next_sel got=%0d exp=2", s4); end
  endtask

  task automatic test_datapath();
    apply_reset();
    req = 4'b1000;
    d   = 4'hB;
    tick();
    n_cmp++; if (s4 !== 2'd3)    begin n_fail++; $display("FAIL data_sel got=%0d exp=3", s4); end
    n_cmp++; if (o4 !== 1'b0)    begin n_fail++; $display("FAIL data_out_lag got=%b exp=0", o4); end
    tick();
    n_cmp++; if (o4 !== 1'b1)    begin n_fail++; $display("FAIL data_out_b got=%b exp=1", o4); end
    d = 4'h0;
    tick();
    n_cmp++; if (o4 !== 1'b0)    begin n_fail++; $display("FAIL data_out_0 got=%b exp=0", o4); end
    d   = 4'hB;
    req = 4'b0000;
    tick();
    n_cmp++; if (g4 !== 4'b0000) begin n_fail++; $display("FAIL data_gap_grant got=%b exp=0000", g4); end
    n_cmp++; if (o4 !== 1'b1)    begin n_fail++; $display("FAIL data_last_out got=%b exp=1", o4); end
    tick();
    n_cmp++; if (o4 !== 1'b0)    begin n_fail++; $display("FAIL data_gap_out got=%b exp=0", o4); end
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    req = 4'b0010;
    d   = 4'hF;
    tick();
    tick();
    n_cmp++; if (o4 !== 1'b1)    begin n_fail++; $display("FAIL midrst_pre_out got=%b exp=1", o4); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (g4 !== 4'b0000) begin n_fail++; $display("FAIL midrst_grant got=%b exp=0000", g4); end
    n_cmp++; if (v4 !== 1'b0)    begin n_fail++; $display("FAIL midrst_valid got=%b exp=0", v4); end
    n_cmp++; if (o4 !== 1'b0)    begin n_fail++; $display("FAIL midrst_out got=%b exp=0", o4); end
    n_cmp++; if (s4 !== 2'd0)    begin n_fail++; $display("FAIL midrst_sel got=%0d exp=0", s4); end
    rst_n = 1'b1;
    tick();
    n_cmp++; if (g4 !== 4'b0010) begin n_fail++; $display("FAIL midrst_regrant got=%b exp=0010", g4); end
    n_cmp++; if (s4 !== 2'd1)    begin n_fail++; $display("FAIL midrst_resel got=%0d exp=1", s4); end
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    req  = 4'b0011;
    lock = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_cmp++; if (g2 !== 4'b0001) begin n_fail++; $display("FAIL lock_hold_grant[%0d] got=%b exp=0001", k, g2); end
    end
    lock = 1'b0;
    tick();
    n_cmp++; if (g2 !== 4'b0001) begin n_fail++; $display("FAIL lock_resume got=%b exp=0001", g2); end
    tick();
    n_cmp++; if (g2 !== 4'b0000) begin n_fail++; $display("FAIL lock_gap got=%b exp=0000", g2); end
    tick();
    n_cmp++; if (g2 !== 4'b0010) begin n_fail++; $display("FAIL lock_next got=%b exp=0010", g2); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst_n = 1'b0; req = 4'b0000; d = 4'h0; lock = 1'b0;
    test_reset();
    test_single_hold();
    test_contention();
    test_early_release();
    test_datapath();
    test_reset_mid_grant();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
